// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output and framing/overrun error pulses.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 voting around mid-bit.
module uart_rx #(
  parameter int BUAD_RATE = 9600,
  parameter int CLK_FRE   = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] m_rx_data,
  output logic       m_rx_valid,
  input  logic       m_rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);
  localparam int CNT_MAX = CLK_FRE / BUAD_RATE;
  localparam int HALF    = CNT_MAX / 2;
  localparam int CW      = $clog2(CNT_MAX);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = HALF + 1;
`else
  localparam int DEC = HALF;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [1:0] warm;
  logic s1, rs, prev, armed;
  logic fall, samp, last, bit_v, deliver, ferr;
  // warm/armed keep a line that was low out of reset from looking like a start edge
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1    <= 1'b1;
      rs    <= 1'b1;
      prev  <= 1'b1;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      s1    <= rx;
      rs    <= s1;
      prev  <= rs;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & rs);
    end
  assign fall = armed & prev & ~rs;
  assign samp = cnt == CW'(DEC);
  assign last = cnt == CW'(CNT_MAX - 1);
`ifdef UART_RX_MAJORITY_EN
  logic v0, v1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cnt == CW'(HALF - 1)) v0 <= rs;
      if (cnt == CW'(HALF)) v1 <= rs;
    end
  assign bit_v = (v0 & v1) | (v0 & rs) | (v1 & rs);
`else
  assign bit_v = rs;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = fall ? START : IDLE;
      START: state_nx = (samp && bit_v) ? IDLE : last ? DATA : START;
      DATA:  state_nx = (last && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_nx = samp ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    deliver = state == STOP && samp && bit_v;
    ferr    = state == STOP && samp && !bit_v;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= (state == IDLE || state_nx == IDLE || last) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bit_idx     <= '0;
      shift       <= '0;
      m_rx_data   <= '0;
      m_rx_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      bit_idx     <= state != DATA ? '0 : last ? bit_idx + 1'b1 : bit_idx;
      if (state == DATA && samp) shift <= {bit_v, shift[7:1]};
      frame_err   <= ferr;
      overrun_err <= deliver & m_rx_valid & ~m_rx_ready;
      if (deliver && (!m_rx_valid || m_rx_ready)) m_rx_data <= shift;
      m_rx_valid  <= deliver | (m_rx_valid & ~m_rx_ready);
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx with an 8N1 line model and byte scoreboard.
module tb_uart_rx;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1, m_rx_ready = 1'b0;
  logic [7:0] m_rx_data;
  logic m_rx_valid, frame_err, overrun_err;
  int pass = 0, total = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, rises = 0, rise_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] got[$];
  always #5 clk = ~clk;
  uart_rx #(.BUAD_RATE(1), .CLK_FRE(16)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .m_rx_ready(m_rx_ready), .frame_err(frame_err), .overrun_err(overrun_err)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rstn) begin
      if (m_rx_valid && m_rx_ready) got.push_back(m_rx_data);
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (m_rx_valid && !prev_v) begin
        rises++;
        rise_cyc = cyc;
      end
    end
    prev_v = m_rx_valid;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d required 0 pending", 1);
    $fatal(1);
  end
  // frame index: 0 start, 1..8 data LSB first, 9 stop; glitch flips one clk at offset 9 of a bit
  task automatic send(input logic [7:0] d, input logic stop, input int glitch, input int abort, output int t0);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    t0 = 0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        if (b == abort && c == 8) begin
          rstn = 1'b0;
          return;
        end
        if (b == 0 && c == 0) t0 = cyc;
        rx = fr[b] ^ logic'(b == glitch && c == 9);
      end
    @(posedge clk); #1;
    rx = 1'b1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_rx_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", m_rx_valid); else pass++;
    total++; if (m_rx_data !== 8'h00) $display("FAIL reset_data: got %h required 00", m_rx_data); else pass++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b required 0", frame_err); else pass++;
    total++; if (overrun_err !== 1'b0) $display("FAIL reset_ovr: got %b required 0", overrun_err); else pass++;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
  endtask
  task automatic test_single();
    int t0, n0, f0, o0, r0, lat;
`ifdef UART_RX_MAJORITY_EN
    lat = 2 + 1 + 16 * 9 + 8 + 1 + 1;
`else
    lat = 2 + 1 + 16 * 9 + 8 + 1;
`endif
    n0 = got.size(); f0 = fe_cnt; o0 = ov_cnt; r0 = rises;
    m_rx_ready = 1'b1;
    send(8'h55, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (rises - r0 !== 1) $display("FAIL single_pulses: got %0d required 1", rises - r0); else pass++;
    total++; if (rise_cyc - t0 !== lat) $display("FAIL single_latency: got %0d required %0d", rise_cyc - t0, lat); else pass++;
    total++; if (got.size() !== n0 + 1 || got[n0] !== 8'h55) $display("FAIL single_data: got %0d bytes last %h required 55", got.size() - n0, got[got.size() - 1]); else pass++;
    total++; if (fe_cnt - f0 !== 0) $display("FAIL single_ferr: got %0d required 0", fe_cnt - f0); else pass++;
    total++; if (ov_cnt - o0 !== 0) $display("FAIL single_ovr: got %0d required 0", ov_cnt - o0); else pass++;
  endtask
  task automatic test_overrun();
    int t0, n0, f0, o0;
    n0 = got.size(); f0 = fe_cnt; o0 = ov_cnt;
    m_rx_ready = 1'b0;
    send(8'hA3, 1'b1, -1, -1, t0);
    send(8'h0F, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (m_rx_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b required 1", m_rx_valid); else pass++;
    total++; if (m_rx_data !== 8'hA3) $display("FAIL ovr_data_kept: got %h required a3", m_rx_data); else pass++;
    total++; if (ov_cnt - o0 !== 1) $display("FAIL ovr_pulses: got %0d required 1", ov_cnt - o0); else pass++;
    total++; if (fe_cnt - f0 !== 0) $display("FAIL ovr_ferr: got %0d required 0", fe_cnt - f0); else pass++;
    m_rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 1) $display("FAIL ovr_taken_once: got %0d bytes required 1", got.size() - n0); else pass++;
    total++; if (got.size() > n0 && got[n0] !== 8'hA3) $display("FAIL ovr_taken_data: got %h required a3", got[n0]); else pass++;
    total++; if (m_rx_valid !== 1'b0) $display("FAIL ovr_valid_fall: got %b required 0", m_rx_valid); else pass++;
  endtask
  task automatic test_frame_err();
    int t0, n0, f0, o0, r0;
    n0 = got.size(); f0 = fe_cnt; o0 = ov_cnt; r0 = rises;
    m_rx_ready = 1'b1;
    send(8'h7E, 1'b0, -1, -1, t0);
    repeat (20) @(posedge clk);
    #1;
    total++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_pulses: got %0d required 1", fe_cnt - f0); else pass++;
    total++; if (ov_cnt - o0 !== 0) $display("FAIL ferr_ovr: got %0d required 0", ov_cnt - o0); else pass++;
    total++; if (rises - r0 !== 0) $display("FAIL ferr_no_valid: got %0d required 0", rises - r0); else pass++;
    send(8'h12, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 1 || got[n0] !== 8'h12) $display("FAIL ferr_next: got %0d bytes last %h required 12", got.size() - n0, got[got.size() - 1]); else pass++;
  endtask
  task automatic test_false_start();
    int t0, n0, f0, o0, r0;
    n0 = got.size(); f0 = fe_cnt; o0 = ov_cnt; r0 = rises;
    @(posedge clk); #1; rx = 1'b0;
    repeat (3) @(posedge clk);
    #1; rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++; if (rises - r0 !== 0) $display("FAIL glitch_start_valid: got %0d required 0", rises - r0); else pass++;
    total++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) $display("FAIL glitch_start_err: got %0d required 0", fe_cnt - f0 + ov_cnt - o0); else pass++;
    send(8'h3C, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 1 || got[n0] !== 8'h3C) $display("FAIL glitch_start_next: got %0d bytes last %h required 3c", got.size() - n0, got[got.size() - 1]); else pass++;
  endtask
  task automatic test_reset_mid();
    int t0, n0;
    m_rx_ready = 1'b0;
    send(8'h5A, 1'b1, -1, -1, t0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_rx_valid !== 1'b1) $display("FAIL rstmid_pending: got %b required 1", m_rx_valid); else pass++;
    send(8'hC6, 1'b1, -1, 5, t0);
    #1;
    total++; if (m_rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b required 0", m_rx_valid); else pass++;
    total++; if (m_rx_data !== 8'h00) $display("FAIL rstmid_data: got %h required 00", m_rx_data); else pass++;
    total++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) $display("FAIL rstmid_errs: got %b%b required 00", frame_err, overrun_err); else pass++;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1; rstn = 1'b1;
    m_rx_ready = 1'b1;
    repeat (30) @(posedge clk);
    n0 = got.size();
    send(8'h81, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 1 || got[n0] !== 8'h81) $display("FAIL rstmid_next: got %0d bytes last %h required 81", got.size() - n0, got[got.size() - 1]); else pass++;
  endtask
  task automatic test_glitch();
    int t0, n0;
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h04;
`endif
    n0 = got.size();
    m_rx_ready = 1'b1;
    send(8'h00, 1'b1, 3, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 1 || got[n0] !== exp) $display("FAIL bit_glitch: got %0d bytes last %h required %h", got.size() - n0, got[got.size() - 1], exp); else pass++;
  endtask
  task automatic test_back_to_back();
    int t0, n0, f0, o0;
    logic done;
    logic [7:0] exp[$];
    n0 = got.size(); f0 = fe_cnt; o0 = ov_cnt;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] d;
          d = 8'($urandom);
          exp.push_back(d);
          send(d, 1'b1, -1, -1, t0);
          repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        m_rx_ready = 1'($urandom_range(0, 1));
      end
    join
    m_rx_ready = 1'b1;
    for (int i = 0; i < 60 && got.size() < n0 + 8; i++) @(posedge clk);
    #1;
    total++; if (got.size() !== n0 + 8) $display("FAIL b2b_count: got %0d bytes required 8", got.size() - n0); else pass++;
    total++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) $display("FAIL b2b_errs: got %0d required 0", fe_cnt - f0 + ov_cnt - o0); else pass++;
    for (int i = 0; i < 8 && n0 + i < got.size(); i++) begin
      total++; if (got[n0 + i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h required %h", i, got[n0 + i], exp[i]); else pass++;
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_false_start();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
